// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional macro MCTRL_BNE_EN adds bne (op 000101) through the BRANCH state.
module mips_multicycle_ctrl #(
  parameter int STATE_W  = 4,
  parameter int RETIRE_W = 32
) (
  input  logic                inp_clk,
  input  logic                inp_rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                ir_write,
  output logic                mem_write,
  output logic                iord,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [2:0]          alu_ctl,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  output logic [STATE_W-1:0]  dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic                pc_en_raw, ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;
  logic                branch_taken;

`ifdef MCTRL_BNE_EN
  logic is_bne_q, is_bne_d;

  always_comb begin
    is_bne_d = is_bne_q;
    if (state_q == DECODE) is_bne_d = (op == OP_BNE);
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) is_bne_q <= 1'b0;
    else            is_bne_q <= is_bne_d;
  end

  assign branch_taken = is_bne_q ? ~zero : zero;
`else
  assign branch_taken = zero;
`endif

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = FETCH;
    retire        = 1'b0;
    pc_en_raw     = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_ctl       = ALU_ADD;
    case (state_q)
      FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        state_d      = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MCTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        retire        = mem_ready;
        state_d       = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        state_d   = ALUWB;
        case (funct)
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_src    = 2'b01;
        pc_en_raw = branch_taken;
        retire    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_src    = 2'b10;
        pc_en_raw = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + RETIRE_W'(1);
  end

  // Strobes are forced low while reset is held so FETCH's ready-gated strobes stay quiet.
  assign pc_en     = inp_rst_n & pc_en_raw;
  assign ir_write  = inp_rst_n & ir_write_raw;
  assign mem_write = inp_rst_n & mem_write_raw;
  assign reg_write = inp_rst_n & reg_write_raw;
  assign illegal   = inp_rst_n & illegal_raw;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: planned per-instruction state/ready sequences checked cycle by cycle.
module tb_mips_multicycle_ctrl;

  logic        inp_clk = 1'b0;
  logic        inp_rst_n;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctl;
  logic [31:0] retired;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  int  pst[$];
  bit  pmr[$];
  bit  pill[$];

  always #5 inp_clk = ~inp_clk;

  mips_multicycle_ctrl #(.STATE_W(4), .RETIRE_W(32)) dut (
    .inp_clk(inp_clk), .inp_rst_n(inp_rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctl(alu_ctl),
    .illegal(illegal), .retired(retired), .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // One clock of an instruction: drive ready/zero, compare every output to the state's table row.
  task automatic step(input int st, input bit mr, input bit ill, input bit bne_k);
    bit z;
    logic [2:0] ea;
    bit epc;
    logic [1:0] eb, eps;
    z = bit'($urandom_range(0, 1));
    mem_ready = mr;
    zero = z;
    #3;
    ea  = (st == 6) ? alu_of(funct) : (st == 8) ? 3'b110 : 3'b010;
    epc = (st == 0) ? mr : (st == 8) ? (bne_k ? ~z : z) : (st == 11);
    eb  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 9) ? 2'b10 : 2'b00;
    eps = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
    check_eq("state", 32'(dbg_state), 32'(st));
    check_eq("ir_write", 32'(ir_write), 32'(st == 0 && mr));
    check_eq("mem_write", 32'(mem_write), 32'(st == 5));
    check_eq("reg_write", 32'(reg_write), 32'(st == 4 || st == 7 || st == 10));
    check_eq("illegal", 32'(illegal), 32'(ill));
    check_eq("pc_en", 32'(pc_en), 32'(epc));
    check_eq("alu_ctl", 32'(alu_ctl), 32'(ea));
    check_eq("iord", 32'(iord), 32'(st == 3 || st == 5));
    check_eq("reg_dst", 32'(reg_dst), 32'(st == 7));
    check_eq("mem_to_reg", 32'(mem_to_reg), 32'(st == 4));
    check_eq("alu_src_a", 32'(alu_src_a), 32'(st == 2 || st == 6 || st == 8 || st == 9));
    check_eq("alu_src_b", 32'(alu_src_b), 32'(eb));
    check_eq("pc_src", 32'(pc_src), 32'(eps));
    check_eq("retired", retired, 32'(exp_ret));
    @(posedge inp_clk);
    #1;
  endtask

  task automatic push(input int st, input bit mr, input bit ill);
    pst.push_back(st);
    pmr.push_back(mr);
    pill.push_back(ill);
  endtask

  function automatic bit legal_op(input logic [5:0] o);
    return o == 6'h23 || o == 6'h2b || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02 || o == 6'h05;
  endfunction

  initial begin
    #300000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int kind, wf, wm;
    bit bne_ok, retires, is_bne;
    logic [5:0] fv[5];
`ifdef MCTRL_BNE_EN
    bne_ok = 1'b1;
`else
    bne_ok = 1'b0;
`endif
    fv[0] = 6'b100000; fv[1] = 6'b100010; fv[2] = 6'b100100; fv[3] = 6'b100101; fv[4] = 6'b101010;

    inp_rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b0;
    op = 6'h23;
    funct = 6'h20;
    #2;
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_ir_write", 32'(ir_write), 32'd0);
    check_eq("rst_pc_en", 32'(pc_en), 32'd0);
    check_eq("rst_reg_write", 32'(reg_write), 32'd0);
    @(posedge inp_clk);
    @(posedge inp_clk);
    #1;
    inp_rst_n = 1'b1;

    for (int n = 0; n < 220; n++) begin
      kind = $urandom_range(0, 8);
      wf = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      funct = 6'($urandom_range(0, 63));
      is_bne = 1'b0;
      retires = 1'b1;
      case (kind)
        0: op = 6'h23;
        1: op = 6'h2b;
        2: begin op = 6'h00; funct = fv[$urandom_range(0, 4)]; end
        3: begin
          op = 6'h00;
          while (alu_of(funct) == 3'b010 && funct == 6'b100000) funct = 6'($urandom_range(0, 63));
          while (funct == fv[0] || funct == fv[1] || funct == fv[2] || funct == fv[3] || funct == fv[4])
            funct = 6'($urandom_range(0, 63));
        end
        4: op = 6'h04;
        5: op = 6'h08;
        6: op = 6'h02;
        7: begin
          op = 6'($urandom_range(0, 63));
          while (legal_op(op)) op = 6'($urandom_range(0, 63));
        end
        default: begin op = 6'h05; is_bne = 1'b1; end
      endcase

      pst.delete(); pmr.delete(); pill.delete();
      for (int i = 0; i < wf; i++) push(0, 1'b0, 1'b0);
      push(0, 1'b1, 1'b0);
      case (kind)
        0: begin
          push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0);
          for (int i = 0; i < wm; i++) push(3, 1'b0, 1'b0);
          push(3, 1'b1, 1'b0); push(4, 1'b0, 1'b0);
        end
        1: begin
          push(1, 1'b1, 1'b0); push(2, 1'b0, 1'b0);
          for (int i = 0; i < wm; i++) push(5, 1'b0, 1'b0);
          push(5, 1'b1, 1'b0);
        end
        2: begin push(1, 1'b0, 1'b0); push(6, 1'b0, 1'b0); push(7, 1'b1, 1'b0); end
        3: begin push(1, 1'b1, 1'b0); push(6, 1'b0, 1'b1); retires = 1'b0; end
        4: begin push(1, 1'b0, 1'b0); push(8, 1'b1, 1'b0); end
        5: begin push(1, 1'b1, 1'b0); push(9, 1'b0, 1'b0); push(10, 1'b1, 1'b0); end
        6: begin push(1, 1'b0, 1'b0); push(11, 1'b1, 1'b0); end
        7: begin push(1, 1'b1, 1'b1); retires = 1'b0; end
        default: begin
          if (bne_ok) begin push(1, 1'b0, 1'b0); push(8, 1'b1, 1'b0); end
          else begin push(1, 1'b0, 1'b1); retires = 1'b0; end
        end
      endcase

      for (int i = 0; i < pst.size(); i++) step(pst[i], pmr[i], pill[i], is_bne);
      if (retires) exp_ret++;
    end

    // Abort a store while it waits in MEMWR.
    op = 6'h2b;
    step(0, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2;
    check_eq("mw_before_rst", 32'(mem_write), 32'd1);
    check_eq("state_before_rst", 32'(dbg_state), 32'd5);
    inp_rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("mw_in_rst", 32'(mem_write), 32'd0);
    check_eq("state_in_rst", 32'(dbg_state), 32'd0);
    check_eq("retired_in_rst", retired, 32'd0);
    check_eq("ir_write_in_rst", 32'(ir_write), 32'd0);
    @(posedge inp_clk);
    #1;
    check_eq("state_held_rst", 32'(dbg_state), 32'd0);
    check_eq("reg_write_held_rst", 32'(reg_write), 32'd0);
    inp_rst_n = 1'b1;
    exp_ret = 0;
    step(0, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0);
    step(5, 1'b1, 1'b0, 1'b0);
    exp_ret++;
    mem_ready = 1'b0;
    #3;
    check_eq("retired_after_sw", retired, 32'(exp_ret));
    check_eq("state_after_sw", 32'(dbg_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
